// File: rtl/stream_merge_sorter.sv
// Streaming rank-merge sorter: absorbs pre-sorted CHUNK-element beats into a sorted
// N-element buffer and presents the full block. Optional checker: STREAM_MERGE_SORT_CHECK_EN.
`timescale 1ns/1ps
module stream_merge_sorter #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4,
    parameter int N     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CHUNK*WIDTH-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N*WIDTH-1:0]       out_data,
    output logic [$clog2(N):0]       fill_level,
    output logic                     sort_err
);
    localparam int PW = $clog2(N) + 1;

    typedef enum logic {S_FILL, S_FULL} state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          fill_q, fill_d;
    logic [WIDTH-1:0]       buf_q [N];
    logic [WIDTH-1:0]       buf_d [N];
    logic [WIDTH-1:0]       merged [N];
    logic [WIDTH-1:0]       new_el [CHUNK];
    logic [PW-1:0]          rank_b [N];
    logic [PW-1:0]          rank_n [CHUNK];
    logic                   accept;
    logic                   handoff;

    assign in_ready   = (state_q == S_FILL) && !rst;
    assign out_valid  = (state_q == S_FULL);
    assign fill_level = fill_q;
    assign accept     = in_valid && in_ready && !clr;
    assign handoff    = out_valid && out_ready && !clr;

    genvar gi;
    generate
        for (gi = 0; gi < CHUNK; gi++) begin : g_unpack
            assign new_el[gi] = in_data[gi*WIDTH +: WIDTH];
        end
        for (gi = 0; gi < N; gi++) begin : g_pack
            assign out_data[gi*WIDTH +: WIDTH] = buf_q[gi];
        end

        // Existing element moves up by the number of strictly smaller newcomers.
        for (gi = 0; gi < N; gi++) begin : g_rank_buf
            always_comb begin
                rank_b[gi] = PW'(gi);
                for (int j = 0; j < CHUNK; j++) begin
                    if (new_el[j] < buf_q[gi]) rank_b[gi] = rank_b[gi] + PW'(1);
                end
            end
        end

        // Newcomer moves up by the number of valid buffer elements <= it (stable ties).
        for (gi = 0; gi < CHUNK; gi++) begin : g_rank_new
            always_comb begin
                rank_n[gi] = PW'(gi);
                for (int i = 0; i < N; i++) begin
                    if ((PW'(i) < fill_q) && (buf_q[i] <= new_el[gi]))
                        rank_n[gi] = rank_n[gi] + PW'(1);
                end
            end
        end
    endgenerate

    always_comb begin
        for (int p = 0; p < N; p++) begin
            merged[p] = buf_q[p];
        end
        for (int p = 0; p < N; p++) begin
            for (int i = 0; i < N; i++) begin
                if ((PW'(i) < fill_q) && (rank_b[i] == PW'(p))) merged[p] = buf_q[i];
            end
            for (int j = 0; j < CHUNK; j++) begin
                if (rank_n[j] == PW'(p)) merged[p] = new_el[j];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        for (int p = 0; p < N; p++) begin
            buf_d[p] = buf_q[p];
        end
        if (clr) begin
            state_d = S_FILL;
            fill_d  = '0;
        end else if (accept) begin
            for (int p = 0; p < N; p++) begin
                buf_d[p] = merged[p];
            end
            fill_d = fill_q + PW'(CHUNK);
            if (fill_q + PW'(CHUNK) == PW'(N)) state_d = S_FULL;
        end else if (handoff) begin
            state_d = S_FILL;
            fill_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FILL;
            fill_q  <= '0;
            for (int p = 0; p < N; p++) begin
                buf_q[p] <= '0;
            end
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            for (int p = 0; p < N; p++) begin
                buf_q[p] <= buf_d[p];
            end
        end
    end

`ifdef STREAM_MERGE_SORT_CHECK_EN
    logic unsorted;
    logic err_q, err_d;

    always_comb begin
        unsorted = 1'b0;
        for (int j = 0; j < CHUNK - 1; j++) begin
            if (new_el[j] > new_el[j+1]) unsorted = 1'b1;
        end
    end

    // Sticky: only rst clears it, clr deliberately leaves it set.
    always_comb begin
        err_d = err_q;
        if (accept && unsorted) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign sort_err = err_q;
`else
    assign sort_err = 1'b0;
`endif

endmodule

// File: tb/tb_stream_merge_sorter.sv
// Directed, table-driven bench for stream_merge_sorter (default parameters).
`timescale 1ns/1ps
module tb_stream_merge_sorter;
    localparam int W  = 8;
    localparam int C  = 4;
    localparam int N  = 16;
    localparam int FW = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [C*W-1:0]   in_data;
    logic             out_valid;
    logic             out_ready;
    logic [N*W-1:0]   out_data;
    logic [FW-1:0]    fill_level;
    logic             sort_err;

    stream_merge_sorter #(.WIDTH(W), .CHUNK(C), .N(N)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .fill_level(fill_level), .sort_err(sort_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [C*W-1:0] chunk;
        logic [FW-1:0]  fill;
        logic           valid;
    } vec_t;

    vec_t           vecs [12];
    logic [N*W-1:0] exp_blk [3];

`ifdef STREAM_MERGE_SORT_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [C*W-1:0] mk(input logic [7:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic send(input logic [C*W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic handoff(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_handoff_valid"}, out_valid, 0);
        chk({tag, "_handoff_ready"}, in_ready, 1);
        chk({tag, "_handoff_fill"}, fill_level, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        byte unsigned b1 [16] = '{7,8,9,10,20,21,22,23,31,32,33,34,41,42,43,44};
        byte unsigned b3 [16] = '{0,5,5,5,5,5,5,5,5,9,9,255,255,255,255,255};
        vec_t v;

        for (int k = 0; k < 16; k++) begin
            exp_blk[0][k*W +: W] = b1[k];
            exp_blk[1][k*W +: W] = 8'(k);
            exp_blk[2][k*W +: W] = b3[k];
        end
        vecs[0]  = '{mk(7,8,9,10),        5'd4,  1'b0};
        vecs[1]  = '{mk(20,21,22,23),     5'd8,  1'b0};
        vecs[2]  = '{mk(31,32,33,34),     5'd12, 1'b0};
        vecs[3]  = '{mk(41,42,43,44),     5'd16, 1'b1};
        vecs[4]  = '{mk(1,5,9,13),        5'd4,  1'b0};
        vecs[5]  = '{mk(2,6,10,14),       5'd8,  1'b0};
        vecs[6]  = '{mk(3,7,11,15),       5'd12, 1'b0};
        vecs[7]  = '{mk(0,4,8,12),        5'd16, 1'b1};
        vecs[8]  = '{mk(5,5,5,5),         5'd4,  1'b0};
        vecs[9]  = '{mk(5,5,9,9),         5'd8,  1'b0};
        vecs[10] = '{mk(0,5,5,255),       5'd12, 1'b0};
        vecs[11] = '{mk(255,255,255,255), 5'd16, 1'b1};

        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_fill", fill_level, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sort_err", sort_err, 0);
        chk("rst_out_data", out_data, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_in_ready", in_ready, 1);

        for (int b = 0; b < 3; b++) begin
            for (int r = 0; r < 4; r++) begin
                v = vecs[b*4 + r];
                in_valid = 1'b1;
                in_data  = v.chunk;
                @(posedge clk); #1;
                chk($sformatf("blk%0d_c%0d_fill", b, r), fill_level, v.fill);
                chk($sformatf("blk%0d_c%0d_valid", b, r), out_valid, v.valid);
                chk($sformatf("blk%0d_c%0d_ready", b, r), in_ready, !v.valid);
                if (b == 1 && r == 1)
                    chk("interleave_buf8", out_data[8*W-1:0], 64'h0e0d_0a09_0605_0201);
            end
            in_valid = 1'b0;
            chk($sformatf("blk%0d_out_data", b), out_data, exp_blk[b]);
            if (b == 0) begin
                // Backpressure, with a stray chunk offered that must be ignored.
                in_valid = 1'b1;
                in_data  = mk(0, 0, 0, 0);
                for (int h = 0; h < 3; h++) begin
                    @(posedge clk); #1;
                    chk($sformatf("bp%0d_valid", h), out_valid, 1);
                    chk($sformatf("bp%0d_data", h), out_data, exp_blk[0]);
                    chk($sformatf("bp%0d_ready", h), in_ready, 0);
                    chk($sformatf("bp%0d_fill", h), fill_level, 16);
                end
                in_valid = 1'b0;
            end
            handoff($sformatf("blk%0d", b));
        end

        // clr together with in_valid: chunk must not be absorbed.
        send(vecs[4].chunk);
        send(vecs[5].chunk);
        clr = 1'b1; in_valid = 1'b1; in_data = vecs[6].chunk;
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        chk("clr_fill", fill_level, 0);
        chk("clr_valid", out_valid, 0);
        chk("clr_ready", in_ready, 1);
        for (int r = 4; r < 8; r++) send(vecs[r].chunk);
        chk("post_clr_valid", out_valid, 1);
        chk("post_clr_data", out_data, exp_blk[1]);
        handoff("post_clr");

        // Asynchronous rst mid-cycle during a partial fill.
        send(vecs[0].chunk);
        send(vecs[1].chunk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_fill", fill_level, 0);
        chk("arst_ready", in_ready, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_release_ready", in_ready, 1);

        // Unsorted chunk: flag only exists when the checker is built.
        send(mk(4, 3, 8, 9));
        chk("unsorted_fill", fill_level, 4);
        chk("unsorted_err", sort_err, EXP_ERR);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("err_after_clr_fill", fill_level, 0);
        chk("err_after_clr", sort_err, EXP_ERR);
        send(mk(1, 2, 3, 4));
        chk("err_sticky_sorted", sort_err, EXP_ERR);
        rst = 1'b1;
        #2;
        chk("err_rst", sort_err, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
